// File: rtl/sfr_port_arbiter_if.sv
// Background requester bus for the SFR port arbiter: two requesters,
// each with a request/ack handshake and a 16-bit data path.
interface sfr_port_arbiter_if #(
  parameter int SFR_AW = 5,
  parameter int DATA_W = 8
);
  logic [1:0]          rq_req;
  logic [1:0]          rq_we;
  logic [1:0]          rq_wide;
  logic [2*SFR_AW-1:0] rq_addr;
  logic [4*DATA_W-1:0] rq_wdata;
  logic [1:0]          rq_ack;
  logic [2*DATA_W-1:0] rq_rdata;

  modport master (
    output rq_req, rq_we, rq_wide, rq_addr, rq_wdata,
    input  rq_ack, rq_rdata
  );

  modport slave (
    input  rq_req, rq_we, rq_wide, rq_addr, rq_wdata,
    output rq_ack, rq_rdata
  );
endinterface

// File: rtl/sfr_port_arbiter.sv
// Shares the SFR file port between the CPU memory stage (always first,
// zero latency) and two background requesters (interrupt controller,
// debug port). Background transactions are 8- or 16-bit, arbitrated
// round-robin, and only use cycles the CPU leaves idle.
module sfr_port_arbiter #(
  parameter int SFR_AW = 5,
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              nreset,
  // CPU side
  input  logic              cpu_wr_en,
  input  logic              cpu_rd_en,
  input  logic [SFR_AW-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic [6:0]        cpu_ptr_ctl,
  input  logic              cpu_call_sel,
  output logic [DATA_W-1:0] cpu_rdata,
  // background requesters
  sfr_port_arbiter_if.slave rq,
  output logic              busy,
  // SFR file side
  output logic [1:0]        sfr_wren,
  output logic [SFR_AW-1:0] sfr_wr_addr,
  output logic [SFR_AW-1:0] sfr_rd_addr,
  output logic [DATA_W-1:0] sfr_write_data,
  output logic [6:0]        sfr_mem_ptr_ctl,
  output logic              sfr_call_stk_addr_sel,
  input  logic [DATA_W-1:0] sfr_read_data
);

  typedef enum logic [2:0] {IDLE, LO, HI, RWAIT, DONE} state_t;

  state_t              state, state_nxt;
  logic                grant, grant_nxt, last_grant;
  logic                load;
  logic                lat_we, lat_wide;
  logic [SFR_AW-1:0]   lat_addr;
  logic [2*DATA_W-1:0] lat_wdata;
  logic                cap_vld, cap_hi;
  logic [2*DATA_W-1:0] rdata_q;
  logic                cpu_busy, beat, hi_sel;
  logic [SFR_AW-1:0]   beat_addr;
  logic [DATA_W-1:0]   beat_byte;

  assign cpu_busy  = cpu_wr_en | cpu_rd_en | (|cpu_ptr_ctl);
  assign hi_sel    = (state == HI);
  assign beat      = !cpu_busy && ((state == LO) || hi_sel);
  assign beat_addr = lat_addr + SFR_AW'(hi_sel);
  assign beat_byte = hi_sel ? lat_wdata[2*DATA_W-1:DATA_W] : lat_wdata[DATA_W-1:0];

  assign busy        = (state != IDLE);
  assign cpu_rdata   = sfr_read_data;
  assign rq.rq_ack   = (state == DONE) ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign rq.rq_rdata = rdata_q;

  // Next-state and grant decision; the port is only needed in LO/HI.
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (|rq.rq_req) begin
          load      = 1'b1;
          grant_nxt = (&rq.rq_req) ? ~last_grant : rq.rq_req[1];
          state_nxt = LO;
        end
      end
      LO: begin
        if (!cpu_busy) begin
          if (lat_wide)    state_nxt = HI;
          else if (lat_we) state_nxt = DONE;
          else             state_nxt = RWAIT;
        end
      end
      HI: begin
        if (!cpu_busy) state_nxt = lat_we ? DONE : RWAIT;
      end
      RWAIT: begin
        // RWAIT is entered right after the final read beat, so the
        // capture in flight here is always the last byte.
        if (cap_vld && (cap_hi == lat_wide)) state_nxt = DONE;
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state: FSM, grant history, capture flag and result register.
  always_ff @(posedge clock) begin
    if (!nreset) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cap_vld    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state   <= state_nxt;
      grant   <= grant_nxt;
      cap_vld <= beat && !lat_we;
      if (state == DONE) last_grant <= grant;
      if (load) begin
        rdata_q <= '0;
      end else if (cap_vld) begin
        if (cap_hi) rdata_q[2*DATA_W-1:DATA_W] <= sfr_read_data;
        else        rdata_q[DATA_W-1:0]        <= sfr_read_data;
      end
    end
  end

  // Transaction fields latched at grant; which byte a read beat targets.
  always_ff @(posedge clock) begin
    cap_hi <= hi_sel;
    if (load) begin
      lat_we    <= grant_nxt ? rq.rq_we[1]   : rq.rq_we[0];
      lat_wide  <= grant_nxt ? rq.rq_wide[1] : rq.rq_wide[0];
      lat_addr  <= grant_nxt ? rq.rq_addr[2*SFR_AW-1:SFR_AW] : rq.rq_addr[SFR_AW-1:0];
      lat_wdata <= grant_nxt ? rq.rq_wdata[4*DATA_W-1:2*DATA_W] : rq.rq_wdata[2*DATA_W-1:0];
    end
  end

  // SFR port mux: CPU first, then a background beat, else quiet.
  always_comb begin
    sfr_wren              = 2'b00;
    sfr_wr_addr           = '0;
    sfr_rd_addr           = '0;
    sfr_write_data        = '0;
    sfr_mem_ptr_ctl       = '0;
    sfr_call_stk_addr_sel = cpu_call_sel;
    if (!nreset) begin
      sfr_call_stk_addr_sel = 1'b0;
    end else if (cpu_busy) begin
      sfr_wren        = {cpu_rd_en, cpu_wr_en};
      sfr_wr_addr     = cpu_addr;
      sfr_rd_addr     = cpu_addr;
      sfr_write_data  = cpu_wdata;
      sfr_mem_ptr_ctl = cpu_ptr_ctl;
    end else if (beat) begin
      sfr_wren       = lat_we ? 2'b01 : 2'b10;
      sfr_wr_addr    = beat_addr;
      sfr_rd_addr    = beat_addr;
      sfr_write_data = beat_byte;
    end
  end

endmodule

// File: tb/tb_sfr_port_arbiter.sv
// Directed bench for sfr_port_arbiter with a behavioural SFR file model.
module tb_sfr_port_arbiter;

  logic       clock = 1'b0;
  logic       nreset;
  logic       cpu_wr_en, cpu_rd_en, cpu_call_sel;
  logic [4:0] cpu_addr;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic [6:0] cpu_ptr_ctl;
  logic       busy;
  logic [1:0] sfr_wren;
  logic [4:0] sfr_wr_addr, sfr_rd_addr;
  logic [7:0] sfr_write_data, sfr_read_data;
  logic [6:0] sfr_mem_ptr_ctl;
  logic       sfr_call_stk_addr_sel;

  int n_vec = 0;
  int n_err = 0;

  sfr_port_arbiter_if rq_bus ();

  sfr_port_arbiter dut (
    .clock                 (clock),
    .nreset                (nreset),
    .cpu_wr_en             (cpu_wr_en),
    .cpu_rd_en             (cpu_rd_en),
    .cpu_addr              (cpu_addr),
    .cpu_wdata             (cpu_wdata),
    .cpu_ptr_ctl           (cpu_ptr_ctl),
    .cpu_call_sel          (cpu_call_sel),
    .cpu_rdata             (cpu_rdata),
    .rq                    (rq_bus),
    .busy                  (busy),
    .sfr_wren              (sfr_wren),
    .sfr_wr_addr           (sfr_wr_addr),
    .sfr_rd_addr           (sfr_rd_addr),
    .sfr_write_data        (sfr_write_data),
    .sfr_mem_ptr_ctl       (sfr_mem_ptr_ctl),
    .sfr_call_stk_addr_sel (sfr_call_stk_addr_sel),
    .sfr_read_data         (sfr_read_data)
  );

  always #5 clock = ~clock;

  // SFR file model: synchronous write, registered read data.
  logic [7:0] sfr_mem [32];
  always @(posedge clock) begin
    if (sfr_wren[0]) sfr_mem[sfr_wr_addr] <= sfr_write_data;
    if (sfr_wren[1]) sfr_read_data <= sfr_mem[sfr_rd_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic smp();
    @(negedge clock);
  endtask

  task automatic cpu_idle();
    cpu_wr_en   = 1'b0;
    cpu_rd_en   = 1'b0;
    cpu_addr    = '0;
    cpu_wdata   = '0;
    cpu_ptr_ctl = '0;
  endtask

  task automatic rq_clear();
    rq_bus.rq_req   = '0;
    rq_bus.rq_we    = '0;
    rq_bus.rq_wide  = '0;
    rq_bus.rq_addr  = '0;
    rq_bus.rq_wdata = '0;
  endtask

  task automatic cpu_write(input logic [4:0] a, input logic [7:0] d);
    cyc();
    cpu_wr_en = 1'b1;
    cpu_addr  = a;
    cpu_wdata = d;
    cyc();
    cpu_idle();
  endtask

  task automatic test_reset();
    nreset       = 1'b0;
    cpu_wr_en    = 1'b1;
    cpu_rd_en    = 1'b1;
    cpu_addr     = 5'd5;
    cpu_wdata    = 8'hAA;
    cpu_ptr_ctl  = 7'h7F;
    cpu_call_sel = 1'b1;
    rq_clear();
    cyc();
    smp();
    n_vec++; if (sfr_wren !== 2'b00) begin $display("FAIL rst_wren: got %h required 0", sfr_wren); n_err++; end
    n_vec++; if (sfr_wr_addr !== 5'd0) begin $display("FAIL rst_wr_addr: got %h required 0", sfr_wr_addr); n_err++; end
    n_vec++; if (sfr_write_data !== 8'd0) begin $display("FAIL rst_wdata: got %h required 0", sfr_write_data); n_err++; end
    n_vec++; if (sfr_mem_ptr_ctl !== 7'd0) begin $display("FAIL rst_ptr: got %h required 0", sfr_mem_ptr_ctl); n_err++; end
    n_vec++; if (sfr_call_stk_addr_sel !== 1'b0) begin $display("FAIL rst_call_sel: got %b required 0", sfr_call_stk_addr_sel); n_err++; end
    cyc();
    nreset = 1'b1;
    cpu_idle();
    smp();
    n_vec++; if (busy !== 1'b0) begin $display("FAIL post_rst_busy: got %b required 0", busy); n_err++; end
    n_vec++; if (rq_bus.rq_ack !== 2'b00) begin $display("FAIL post_rst_ack: got %b required 00", rq_bus.rq_ack); n_err++; end
    n_vec++; if (rq_bus.rq_rdata !== 16'h0000) begin $display("FAIL post_rst_rdata: got %h required 0000", rq_bus.rq_rdata); n_err++; end
    n_vec++; if (sfr_call_stk_addr_sel !== 1'b1) begin $display("FAIL idle_call_sel: got %b required 1", sfr_call_stk_addr_sel); n_err++; end
    cpu_call_sel = 1'b0;
  endtask

  task automatic test_cpu_passthrough();
    cyc();
    cpu_wr_en = 1'b1; cpu_addr = 5'd5; cpu_wdata = 8'hA5; cpu_call_sel = 1'b1;
    smp();
    n_vec++; if (sfr_wren !== 2'b01) begin $display("FAIL cpu_wr_wren: got %b required 01", sfr_wren); n_err++; end
    n_vec++; if (sfr_wr_addr !== 5'd5 || sfr_rd_addr !== 5'd5) begin $display("FAIL cpu_wr_addr: got %h/%h required 05/05", sfr_wr_addr, sfr_rd_addr); n_err++; end
    n_vec++; if (sfr_write_data !== 8'hA5) begin $display("FAIL cpu_wr_data: got %h required a5", sfr_write_data); n_err++; end
    n_vec++; if (sfr_call_stk_addr_sel !== 1'b1) begin $display("FAIL cpu_call_sel: got %b required 1", sfr_call_stk_addr_sel); n_err++; end
    cyc();
    cpu_wr_en = 1'b0; cpu_rd_en = 1'b1; cpu_ptr_ctl = 7'b0100000; cpu_call_sel = 1'b0;
    smp();
    n_vec++; if (sfr_wren !== 2'b10) begin $display("FAIL cpu_rd_wren: got %b required 10", sfr_wren); n_err++; end
    n_vec++; if (sfr_mem_ptr_ctl !== 7'b0100000) begin $display("FAIL cpu_ptr: got %b required 0100000", sfr_mem_ptr_ctl); n_err++; end
    cyc();
    cpu_idle();
    smp();
    n_vec++; if (cpu_rdata !== 8'hA5) begin $display("FAIL cpu_rdata: got %h required a5", cpu_rdata); n_err++; end
    n_vec++; if (sfr_wren !== 2'b00) begin $display("FAIL cpu_idle_wren: got %b required 00", sfr_wren); n_err++; end
  endtask

  task automatic test_wide_write();
    cyc();
    rq_bus.rq_req = 2'b01; rq_bus.rq_we = 2'b01; rq_bus.rq_wide = 2'b01;
    rq_bus.rq_addr = {5'd0, 5'd2}; rq_bus.rq_wdata = {16'h0000, 16'h1234};
    smp();
    n_vec++; if (sfr_wren !== 2'b00) begin $display("FAIL ww_c0_wren: got %b required 00", sfr_wren); n_err++; end
    cyc(); smp();
    n_vec++; if (sfr_wren !== 2'b01 || sfr_wr_addr !== 5'd2 || sfr_write_data !== 8'h34)
      begin $display("FAIL ww_lo: got wren %b addr %h data %h required 01 02 34", sfr_wren, sfr_wr_addr, sfr_write_data); n_err++; end
    n_vec++; if (rq_bus.rq_ack !== 2'b00) begin $display("FAIL ww_c1_ack: got %b required 00", rq_bus.rq_ack); n_err++; end
    cyc(); smp();
    n_vec++; if (sfr_wren !== 2'b01 || sfr_wr_addr !== 5'd3 || sfr_write_data !== 8'h12)
      begin $display("FAIL ww_hi: got wren %b addr %h data %h required 01 03 12", sfr_wren, sfr_wr_addr, sfr_write_data); n_err++; end
    cyc(); smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b01) begin $display("FAIL ww_ack: got %b required 01", rq_bus.rq_ack); n_err++; end
    n_vec++; if (sfr_wren !== 2'b00) begin $display("FAIL ww_done_wren: got %b required 00", sfr_wren); n_err++; end
    cyc();
    rq_clear();
    smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b00) begin $display("FAIL ww_ack_pulse: got %b required 00", rq_bus.rq_ack); n_err++; end
    cyc();
    cpu_rd_en = 1'b1; cpu_addr = 5'd2;
    cyc();
    cpu_addr = 5'd3;
    smp();
    n_vec++; if (cpu_rdata !== 8'h34) begin $display("FAIL ww_mem2: got %h required 34", cpu_rdata); n_err++; end
    cyc();
    cpu_idle();
    smp();
    n_vec++; if (cpu_rdata !== 8'h12) begin $display("FAIL ww_mem3: got %h required 12", cpu_rdata); n_err++; end
  endtask

  task automatic test_narrow_read_stall();
    cpu_write(5'd24, 8'h5A);
    cyc();
    rq_bus.rq_req = 2'b10; rq_bus.rq_we = 2'b00; rq_bus.rq_wide = 2'b00;
    rq_bus.rq_addr = {5'd24, 5'd0};
    smp();
    n_vec++; if (busy !== 1'b0) begin $display("FAIL nr_c0_busy: got %b required 0", busy); n_err++; end
    cyc();
    cpu_wr_en = 1'b1; cpu_addr = 5'd7; cpu_wdata = 8'h11;
    smp();
    n_vec++; if (sfr_wren !== 2'b01 || sfr_wr_addr !== 5'd7 || sfr_write_data !== 8'h11)
      begin $display("FAIL nr_cpu_first: got wren %b addr %h data %h required 01 07 11", sfr_wren, sfr_wr_addr, sfr_write_data); n_err++; end
    n_vec++; if (busy !== 1'b1) begin $display("FAIL nr_c1_busy: got %b required 1", busy); n_err++; end
    cyc();
    cpu_idle();
    smp();
    n_vec++; if (sfr_wren !== 2'b10 || sfr_rd_addr !== 5'd24)
      begin $display("FAIL nr_beat: got wren %b addr %h required 10 18", sfr_wren, sfr_rd_addr); n_err++; end
    cyc(); smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b00) begin $display("FAIL nr_c3_ack: got %b required 00", rq_bus.rq_ack); n_err++; end
    cyc(); smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b10) begin $display("FAIL nr_ack: got %b required 10", rq_bus.rq_ack); n_err++; end
    n_vec++; if (rq_bus.rq_rdata !== 16'h005A) begin $display("FAIL nr_rdata: got %h required 005a", rq_bus.rq_rdata); n_err++; end
    cyc();
    rq_clear();
  endtask

  task automatic test_round_robin();
    int         rem0 = 2;
    int         rem1 = 1;
    int         nacks = 0;
    int         order [3];
    logic [1:0] seen;
    cyc();
    rq_bus.rq_req = 2'b11; rq_bus.rq_we = 2'b11; rq_bus.rq_wide = 2'b00;
    rq_bus.rq_addr = {5'd9, 5'd8}; rq_bus.rq_wdata = {16'h00B1, 16'h00A0};
    order[0] = -1; order[1] = -1; order[2] = -1;
    for (int i = 0; i < 40 && (rem0 > 0 || rem1 > 0); i++) begin
      smp();
      seen = rq_bus.rq_ack;
      if (seen != 2'b00) begin
        n_vec++; if (!$onehot(seen)) begin $display("FAIL rr_overlap: got %b required one-hot", seen); n_err++; end
        if (nacks < 3) order[nacks] = seen[1] ? 1 : 0;
        nacks++;
      end
      cyc();
      if (seen[0]) begin rem0--; if (rem0 == 0) rq_bus.rq_req[0] = 1'b0; end
      if (seen[1]) begin rem1--; if (rem1 == 0) rq_bus.rq_req[1] = 1'b0; end
    end
    n_vec++; if (nacks != 3) begin $display("FAIL rr_ack_count: got %0d required 3", nacks); n_err++; end
    n_vec++; if (order[0] != 0) begin $display("FAIL rr_order0: got %0d required 0", order[0]); n_err++; end
    n_vec++; if (order[1] != 1) begin $display("FAIL rr_order1: got %0d required 1", order[1]); n_err++; end
    n_vec++; if (order[2] != 0) begin $display("FAIL rr_order2: got %0d required 0", order[2]); n_err++; end
    rq_clear();
  endtask

  task automatic test_wide_read_wrap();
    cpu_write(5'd31, 8'hC3);
    cpu_write(5'd0, 8'h3C);
    cyc();
    rq_bus.rq_req = 2'b01; rq_bus.rq_we = 2'b00; rq_bus.rq_wide = 2'b01;
    rq_bus.rq_addr = {5'd0, 5'd31};
    cyc(); smp();
    n_vec++; if (sfr_wren !== 2'b10 || sfr_rd_addr !== 5'd31)
      begin $display("FAIL wr_lo: got wren %b addr %h required 10 1f", sfr_wren, sfr_rd_addr); n_err++; end
    cyc(); smp();
    n_vec++; if (sfr_wren !== 2'b10 || sfr_rd_addr !== 5'd0)
      begin $display("FAIL wr_hi_wrap: got wren %b addr %h required 10 00", sfr_wren, sfr_rd_addr); n_err++; end
    cyc(); smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b00 || busy !== 1'b1)
      begin $display("FAIL wr_c3: got ack %b busy %b required 00 1", rq_bus.rq_ack, busy); n_err++; end
    cyc(); smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b01) begin $display("FAIL wr_ack: got %b required 01", rq_bus.rq_ack); n_err++; end
    n_vec++; if (rq_bus.rq_rdata !== 16'h3CC3) begin $display("FAIL wr_rdata: got %h required 3cc3", rq_bus.rq_rdata); n_err++; end
    cyc();
    rq_clear();
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    cyc();
    rq_bus.rq_req = 2'b01; rq_bus.rq_we = 2'b01; rq_bus.rq_wide = 2'b01;
    rq_bus.rq_addr = {5'd0, 5'd10}; rq_bus.rq_wdata = {16'h0000, 16'hBEEF};
    cyc(); smp();
    n_vec++; if (sfr_wren !== 2'b01 || sfr_wr_addr !== 5'd10 || sfr_write_data !== 8'hEF)
      begin $display("FAIL rm_lo: got wren %b addr %h data %h required 01 0a ef", sfr_wren, sfr_wr_addr, sfr_write_data); n_err++; end
    cyc();
    nreset = 1'b0;
    cpu_wr_en = 1'b1; cpu_addr = 5'd3; cpu_wdata = 8'h99;
    smp();
    n_vec++; if (sfr_wren !== 2'b00 || sfr_wr_addr !== 5'd0 || sfr_write_data !== 8'h00)
      begin $display("FAIL rm_forced: got wren %b addr %h data %h required 00 00 00", sfr_wren, sfr_wr_addr, sfr_write_data); n_err++; end
    cyc();
    nreset = 1'b1;
    cpu_idle();
    rq_clear();
    smp();
    n_vec++; if (busy !== 1'b0) begin $display("FAIL rm_busy: got %b required 0", busy); n_err++; end
    for (int i = 0; i < 4; i++) begin
      if (rq_bus.rq_ack != 2'b00) acks++;
      cyc(); smp();
    end
    n_vec++; if (acks != 0) begin $display("FAIL rm_no_ack: got %0d acks required 0", acks); n_err++; end
  endtask

  task automatic test_ptr_stall();
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (i == 0) begin
        rq_bus.rq_req = 2'b01; rq_bus.rq_we = 2'b01; rq_bus.rq_wide = 2'b00;
        rq_bus.rq_addr = {5'd0, 5'd12}; rq_bus.rq_wdata = {16'h0000, 16'h0077};
      end
      cpu_ptr_ctl = 7'b0000001;
      smp();
      n_vec++; if (sfr_wren !== 2'b00 || sfr_mem_ptr_ctl !== 7'b0000001)
        begin $display("FAIL ps_stall%0d: got wren %b ptr %b required 00 0000001", i, sfr_wren, sfr_mem_ptr_ctl); n_err++; end
    end
    cyc();
    cpu_idle();
    smp();
    n_vec++; if (sfr_wren !== 2'b01 || sfr_wr_addr !== 5'd12 || sfr_write_data !== 8'h77 || sfr_mem_ptr_ctl !== 7'd0)
      begin $display("FAIL ps_beat: got wren %b addr %h data %h ptr %b required 01 0c 77 0", sfr_wren, sfr_wr_addr, sfr_write_data, sfr_mem_ptr_ctl); n_err++; end
    cyc(); smp();
    n_vec++; if (rq_bus.rq_ack !== 2'b01) begin $display("FAIL ps_ack: got %b required 01", rq_bus.rq_ack); n_err++; end
    cyc();
    rq_clear();
  endtask

  initial begin
    test_reset();
    test_cpu_passthrough();
    test_wide_write();
    test_narrow_read_stall();
    test_round_robin();
    test_wide_read_wrap();
    test_reset_mid();
    test_ptr_stall();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/sfr_port_arbiter.md
# sfr_port_arbiter

Shares the special function register file's single write/read port and pointer-control lines between the memory-stage pipeline (CPU) and two background requesters: requester 0 is the interrupt controller and requester 1 is the debug/host port. The CPU always has priority and passes through with zero added latency. Background requests run only in cycles the CPU leaves the port idle, are arbitrated round-robin, and may be 8-bit or 16-bit (two-beat) transactions. The block sits between the memory stage and the SFR file.

## Interface
- SFR_AW, 5, SFR address width (32 registers)
- clock  in  1  system clock, rising edge
- nreset  in  1  reset, synchronous, active-low
- cpu_wr_en  in  1  CPU byte write request
- cpu_rd_en  in  1  CPU byte read request
- cpu_addr  in  5  CPU SFR address (used for both read and write)
- cpu_wdata  in  8  CPU write byte
- cpu_ptr_ctl  in  7  CPU pointer inc/dec one-hot (Z,Y,X inc, call-stack inc, call-stack dec, stack inc, stack dec)
- cpu_call_sel  in  1  call-stack address select, passthrough
- cpu_rdata  out  8  equals sfr_read_data (valid the cycle after a CPU read)
- rq_req  in  2  request, one bit per requester, held until ack
- rq_we  in  2  1 = write, 0 = read
- rq_wide  in  2  1 = 16-bit transaction
- rq_addr  in  10  requester n address at [5n+4:5n]
- rq_wdata  in  32  requester n data at [16n+15:16n]; low byte only if not wide
- rq_ack  out  2  one-cycle completion pulse
- rq_rdata  out  16  read result, valid with ack; upper byte 0 if not wide
- busy  out  1  FSM not in IDLE
- sfr_wren  out  2  bit 0 = write enable, bit 1 = read enable
- sfr_wr_addr, sfr_rd_addr  out  5 each  SFR addresses
- sfr_write_data  out  8  write byte
- sfr_mem_ptr_ctl  out  7  pointer control
- sfr_call_stk_addr_sel  out  1  equals cpu_call_sel
- sfr_read_data  in  8  SFR registered read data, one-cycle latency

## Operation
- cpu_busy = cpu_wr_en | cpu_rd_en | OR-reduce(cpu_ptr_ctl).
- When cpu_busy is high, the SFR outputs are driven combinationally from the CPU inputs: wren = {cpu_rd_en, cpu_wr_en}, both addresses = cpu_addr. No background beat issues that cycle.
- When cpu_busy is low and the FSM is issuing a beat, the beat owns the port and sfr_mem_ptr_ctl = 0. Otherwise all SFR outputs are 0, except sfr_call_stk_addr_sel, which is passthrough.
- FSM states: IDLE, LO, HI, RWAIT, DONE.
- IDLE: if any rq_req bit is set, grant one requester and latch its we/wide/addr/wdata. Go to LO.
  - Round-robin: if both request, grant the one not granted last. last_grant resets to 1, so requester 0 wins the first tie.
- LO: wait while cpu_busy. Otherwise issue the beat at addr with the low byte. Go to HI if wide; else to RWAIT if read; else to DONE.
- HI: wait while cpu_busy. Otherwise issue the beat at (addr+1) mod 32 with the high byte. Go to RWAIT if read, else DONE. Address 31 wide wraps to 0.
- Read capture: a one-bit flag marks the cycle after each read beat. In that cycle sfr_read_data is registered into the low or high result byte, matching the beat. RWAIT exits to DONE in the cycle the final byte is captured.
- DONE: pulse rq_ack[grant], present rq_rdata, update last_grant, return to IDLE.
  - rq_req is ignored in DONE. A requester holding req past ack starts a new transaction.
- Deasserting rq_req after grant does not abort; the transaction completes and acks.
- Wide transactions are not atomic against CPU traffic: a CPU access or pointer increment may land between LO and HI.

## Timing
- Reset (nreset low at a clock edge):
  - FSM to IDLE, last_grant = 1.
  - rq_ack = 0, rq_rdata = 0, busy = 0, capture flag = 0.
  - All SFR-side outputs are forced 0 combinationally while nreset is low.
- Reset mid-transaction drops it; no ack.
- CPU path adds 0 cycles.
- Uncontended narrow write:
  - cycle 0: grant (IDLE).
  - cycle 1: LO beat.
  - cycle 2: DONE, ack high.
- Uncontended narrow read: LO in cycle 1, data captured in cycle 2, ack in cycle 3.
- Uncontended wide read: LO in 1, HI in 2 (low byte captured), high byte captured in 3, ack in 4.
- Each CPU-busy cycle during LO or HI adds one cycle of delay.

## Test plan
- rq0 wide write, addr 2, data 0x1234, CPU idle -> LO writes 0x34 to 2, HI writes 0x12 to 3, rq_ack[0] pulses in cycle 3.
- rq1 narrow read, addr 24, SFR returns 0x5A; CPU write in the LO cycle -> beat delayed one cycle, rq_rdata = 0x005A with ack in cycle 4.
- Both requesters assert together twice -> grant order 0, 1, 0; no overlapping acks.
- rq0 wide read at addr 31 -> beats at 31 then 0, rq_rdata = {byte0, byte31}.
- Reset asserted in the HI state -> no ack, busy = 0 next cycle, all SFR outputs 0 during reset.
- cpu_ptr_ctl = 7'b0000001 held 3 cycles with rq0 pending -> no beat and sfr_mem_ptr_ctl passthrough during those 3 cycles; beat issues in the 4th.
